// File: rtl/motor_pwm_driver.sv
// Dual H-bridge driver: slew-limited PWM duty, ramp-down + dead coast on reversal, immediate brake.
// Latency: 1 clk input register + wait to next period strobe (brake: 2 clks to state); no backpressure.
module motor_pwm_driver #(
  parameter int PRESC        = 195,
  parameter int RAMP_STEP    = 8,
  parameter int DEAD_PERIODS = 2
) (
  input  logic       iclk,
  input  logic       irst_n,
  input  logic [7:0] iL_spd,
  input  logic [7:0] iR_spd,
  input  logic [1:0] iL_dir,
  input  logic [1:0] iR_dir,
  output logic       oL_en,
  output logic       oL_in1,
  output logic       oL_in2,
  output logic       oR_en,
  output logic       oR_in1,
  output logic       oR_in2,
  output logic [1:0] obusy
);

  localparam int              PW       = (PRESC > 0) ? $clog2(PRESC + 1) : 1;
  localparam logic [PW-1:0]   PRESC_TC = PW'(PRESC);
  localparam logic [8:0]      STEP9    = 9'(RAMP_STEP);
  localparam logic [7:0]      STEP8    = 8'(RAMP_STEP);
  localparam logic [3:0]      DEAD_LD  = 4'(DEAD_PERIODS);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_RAMP_DN = 2'd1;
  localparam logic [1:0] ST_DEAD    = 2'd2;
  localparam logic [1:0] ST_BRAKE   = 2'd3;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_FWD   = 2'b01;
  localparam logic [1:0] DIR_REV   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  logic [PW-1:0]   presc_q, presc_d;
  logic [7:0]      pcnt_q, pcnt_d;
  logic            tick;
  logic            ps;

  // Channel index 0 is the left motor, 1 the right motor.
  logic [1:0][7:0] spd_q, spd_d;
  logic [1:0][1:0] dir_q, dir_d;
  logic [1:0][1:0] st_q, st_d;
  logic [1:0][7:0] duty_q, duty_d;
  logic [1:0][1:0] adir_q, adir_d;
  logic [1:0][3:0] dcnt_q, dcnt_d;
  logic [1:0]      en_q, en_d;
  logic [1:0]      in1_q, in1_d;
  logic [1:0]      in2_q, in2_d;

  logic [1:0][7:0] tgt_eff;
  logic [1:0][7:0] duty_ramp;
  logic [1:0]      busy;

  always_comb begin
    tick    = (presc_q == PRESC_TC);
    ps      = tick && (pcnt_q == 8'd254);
    presc_d = tick ? '0 : presc_q + PW'(1);
    pcnt_d  = pcnt_q;
    if (tick) begin
      pcnt_d = (pcnt_q == 8'd254) ? 8'd0 : pcnt_q + 8'd1;
    end
    spd_d = {iR_spd, iL_spd};
    dir_d = {iR_dir, iL_dir};
  end

  // Slew toward the effective target without overshoot; coast forces target 0.
  always_comb begin
    tgt_eff   = '0;
    duty_ramp = '0;
    busy      = '0;
    for (int c = 0; c < 2; c++) begin
      tgt_eff[c] = (adir_q[c] == DIR_COAST) ? 8'd0 : spd_q[c];
      if (duty_q[c] < tgt_eff[c]) begin
        if (({1'b0, tgt_eff[c]} - {1'b0, duty_q[c]}) > STEP9) begin
          duty_ramp[c] = duty_q[c] + STEP8;
        end else begin
          duty_ramp[c] = tgt_eff[c];
        end
      end else begin
        if (({1'b0, duty_q[c]} - {1'b0, tgt_eff[c]}) > STEP9) begin
          duty_ramp[c] = duty_q[c] - STEP8;
        end else begin
          duty_ramp[c] = tgt_eff[c];
        end
      end
      busy[c] = (st_q[c] != ST_RUN) || (duty_q[c] != tgt_eff[c]);
    end
  end

  always_comb begin
    st_d   = st_q;
    duty_d = duty_q;
    adir_d = adir_q;
    dcnt_d = dcnt_q;
    for (int c = 0; c < 2; c++) begin
      if (dir_q[c] == DIR_BRAKE) begin
        // Brake overrides every state without waiting for a period strobe.
        if (st_q[c] != ST_BRAKE) begin
          st_d[c]   = ST_BRAKE;
          duty_d[c] = 8'd0;
          adir_d[c] = DIR_COAST;
        end
      end else begin
        case (st_q[c])
          ST_RUN: begin
            if (ps) begin
              if (dir_q[c] == adir_q[c]) begin
                duty_d[c] = duty_ramp[c];
              end else begin
                st_d[c] = ST_RAMP_DN;
              end
            end
          end
          ST_RAMP_DN: begin
            if (ps) begin
              if (duty_q[c] == 8'd0) begin
                st_d[c]   = ST_DEAD;
                dcnt_d[c] = DEAD_LD;
                adir_d[c] = DIR_COAST;
              end else begin
                duty_d[c] = (duty_q[c] > STEP8) ? duty_q[c] - STEP8 : 8'd0;
              end
            end
          end
          ST_DEAD: begin
            if (ps) begin
              dcnt_d[c] = (dcnt_q[c] != 4'd0) ? dcnt_q[c] - 4'd1 : 4'd0;
              if (dcnt_q[c] <= 4'd1) begin
                st_d[c]   = ST_RUN;
                adir_d[c] = dir_q[c];
              end
            end
          end
          default: begin
            st_d[c]   = ST_DEAD;
            dcnt_d[c] = DEAD_LD;
            duty_d[c] = 8'd0;
            adir_d[c] = DIR_COAST;
          end
        endcase
      end
    end
  end

  always_comb begin
    en_d  = '0;
    in1_d = '0;
    in2_d = '0;
    for (int c = 0; c < 2; c++) begin
      if (st_q[c] == ST_BRAKE) begin
        en_d[c]  = 1'b1;
        in1_d[c] = 1'b1;
        in2_d[c] = 1'b1;
      end else if (adir_q[c] == DIR_FWD) begin
        in1_d[c] = 1'b1;
        en_d[c]  = (pcnt_q < duty_q[c]);
      end else if (adir_q[c] == DIR_REV) begin
        in2_d[c] = 1'b1;
        en_d[c]  = (pcnt_q < duty_q[c]);
      end
    end
  end

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      presc_q <= '0;
      pcnt_q  <= '0;
      spd_q   <= '0;
      dir_q   <= '0;
      st_q    <= {ST_RUN, ST_RUN};
      duty_q  <= '0;
      adir_q  <= '0;
      dcnt_q  <= '0;
      en_q    <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
    end else begin
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      spd_q   <= spd_d;
      dir_q   <= dir_d;
      st_q    <= st_d;
      duty_q  <= duty_d;
      adir_q  <= adir_d;
      dcnt_q  <= dcnt_d;
      en_q    <= en_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
    end
  end

  assign oL_en  = en_q[0];
  assign oL_in1 = in1_q[0];
  assign oL_in2 = in2_q[0];
  assign oR_en  = en_q[1];
  assign oR_in1 = in1_q[1];
  assign oR_in2 = in2_q[1];
  assign obusy  = busy;

endmodule
